// File: rtl/tick_meter_pkg.sv
// Shared types and default constants for the tick period meter.
// The TICK_SYNC_EN build option lives in tick_edge_detect; nothing here depends on it.
package tick_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    MEASURE   = 2'd2,
    TIMED_OUT = 2'd3
  } meter_state_t;

  localparam int DEF_CNT_W    = 32;
  localparam int DEF_TIMEOUT  = 200;
  localparam int DEF_EXPECTED = 96;
  localparam int DEF_TOL      = 0;

  // Counter must reach TIMEOUT without wrapping, and TIMEOUT below 2 leaves no room to measure.
  function automatic bit timeout_legal(input int timeout, input int cnt_w);
    if (timeout < 2) return 1'b0;
    if (cnt_w >= 31) return 1'b1;
    return (timeout < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for tick_in. With TICK_SYNC_EN defined, tick_in first passes a
// 2-flop synchronizer (adds 2 cycles of latency); otherwise tick_in must be clk-synchronous.
module tick_edge_detect
  import tick_meter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tick_i,
  output logic tick_rise_o
);

  logic tick_s;
  logic prev_q;

`ifdef TICK_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], tick_i};
    end
  end

  assign tick_s = sync_q[1];
`else
  assign tick_s = tick_i;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= tick_s;
    end
  end

  assign tick_rise_o = tick_s & ~prev_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures clock cycles between tick_in rising edges, flags missing ticks and tolerance errors.
// Build option TICK_SYNC_EN: synchronize an asynchronous tick_in (see tick_edge_detect).
//
//  state     | meaning
//  IDLE      | disabled, counter cleared, edges ignored
//  ARM       | enabled, waiting for the first reference edge
//  MEASURE   | counting cycles since last edge, reports period on next edge
//  TIMED_OUT | no edge for TIMEOUT cycles, counter frozen until next edge
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int EXPECTED = DEF_EXPECTED,
  parameter int TOL      = DEF_TOL
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             period_ok,
  output logic             timeout
);

  if (!timeout_legal(TIMEOUT, CNT_W)) begin : g_bad_timeout
    $error("tick_period_meter: TIMEOUT must satisfy 2 <= TIMEOUT < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   EXPECTED_C = (CNT_W+1)'(EXPECTED);
  localparam logic [CNT_W:0]   TOL_C      = (CNT_W+1)'(TOL);

  logic             tick_rise;
  meter_state_t     state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic             ok_q;
  logic             timeout_q;

  tick_edge_detect u_edge (
    .clk_i       (CLOCK_50),
    .rst_n_i     (reset_n),
    .tick_i      (tick_in),
    .tick_rise_o (tick_rise)
  );

  // One extra bit keeps the subtraction from wrapping when count is below EXPECTED.
  logic [CNT_W:0] count_ext;
  logic [CNT_W:0] abs_diff;
  logic           in_tol_d;

  assign count_ext = {1'b0, count_q};
  assign abs_diff  = (count_ext >= EXPECTED_C) ? (count_ext - EXPECTED_C)
                                               : (EXPECTED_C - count_ext);
  assign in_tol_d  = (abs_diff <= TOL_C);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ok_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!enable) begin
        state_q   <= IDLE;
        count_q   <= '0;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            count_q <= '0;
            state_q <= ARM;
          end
          ARM: begin
            if (tick_rise) begin
              count_q <= CNT_W'(1);
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            // An edge on the TIMEOUT cycle still counts as a valid period.
            if (tick_rise) begin
              period_q <= count_q;
              ok_q     <= in_tol_d;
              valid_q  <= 1'b1;
              count_q  <= CNT_W'(1);
            end else if (count_q == TIMEOUT_C) begin
              timeout_q <= 1'b1;
              state_q   <= TIMED_OUT;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
          TIMED_OUT: begin
            // Interval since the last good edge is unknown, so re-arm without reporting.
            if (tick_rise) begin
              count_q   <= CNT_W'(1);
              timeout_q <= 1'b0;
              state_q   <= MEASURE;
            end
          end
          default: begin
            state_q <= IDLE;
            count_q <= '0;
          end
        endcase
      end
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign period_ok    = ok_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: a default-tolerance DUT and a TOL=1 DUT share stimulus;
// expected strobes are queued when pulses are driven and popped when period_valid appears.
module tb_tick_period_meter;

  localparam int CNT_W = 32;
  localparam int EXP   = 96;
`ifdef TICK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int unsigned per;
    bit          ok;
    bit          ok_t;
    int          cyc;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             tick_in;
  logic [CNT_W-1:0] period, period_t;
  logic             period_valid, period_valid_t;
  logic             period_ok, period_ok_t;
  logic             timeout, timeout_t;

  int   cyc;
  int   total;
  int   passed;
  int   last_c;
  exp_t sb[$];
  exp_t mon_e;

  tick_period_meter dut (
    .CLOCK_50     (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .tick_in      (tick_in),
    .period       (period),
    .period_valid (period_valid),
    .period_ok    (period_ok),
    .timeout      (timeout)
  );

  tick_period_meter #(.TOL(1)) dut_tol (
    .CLOCK_50     (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .tick_in      (tick_in),
    .period       (period_t),
    .period_valid (period_valid_t),
    .period_ok    (period_ok_t),
    .timeout      (timeout_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit in_tol(input int p, input int tol);
    int d;
    d = (p > EXP) ? p - EXP : EXP - p;
    return d <= tol;
  endfunction

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Raise tick_in at negedge of cycle c; the DUT sees the edge at the next posedge (c+1).
  task automatic pulse_at(input int c, input int len, input bit expect_period);
    exp_t e;
    goto(c);
    if (expect_period) begin
      e.per  = c - last_c;
      e.ok   = in_tol(c - last_c, 0);
      e.ok_t = in_tol(c - last_c, 1);
      e.cyc  = c + 1 + LAT;
      sb.push_back(e);
    end
    last_c  = c;
    tick_in = 1'b1;
    repeat (len) @(negedge clk);
    tick_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && period_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", period_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_cycle", cyc, mon_e.cyc);
        check("period", period, mon_e.per);
        check("period_ok", period_ok, mon_e.ok);
        check("tol1_valid", period_valid_t, 1);
        check("tol1_ok", period_ok_t, mon_e.ok_t);
      end
    end
  end

  initial begin
    cyc = 0; total = 0; passed = 0; last_c = 0;
    reset_n = 1'b0; enable = 1'b0; tick_in = 1'b0;

    goto(2);
    check("rst_period", period, 0);
    check("rst_valid", period_valid, 0);
    check("rst_ok", period_ok, 0);
    check("rst_timeout", timeout, 0);

    goto(3);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Case 1: steady 96-cycle ticks.
    pulse_at(10, 1, 1'b0);
    pulse_at(106, 1, 1'b1);
    pulse_at(202, 1, 1'b1);
    pulse_at(298, 1, 1'b1);
    check("c1_timeout", timeout, 0);

    // Case 2: 96 then 97.
    pulse_at(394, 1, 1'b1);
    pulse_at(491, 1, 1'b1);

    // Case 3: missing tick, timeout exactly 200 cycles after the edge.
    goto(492 + LAT + 199);
    check("c3_timeout_early", timeout, 0);
    goto(492 + LAT + 200);
    check("c3_timeout_set", timeout, 1);
    check("c3_period_held", period, 97);
    check("c3_ok_held", period_ok, 0);
    pulse_at(800, 1, 1'b0);
    goto(801 + LAT);
    check("c3_timeout_clr", timeout, 0);
    pulse_at(896, 1, 1'b1);

    // Case 4: edge on the exact timeout cycle.
    pulse_at(1096, 1, 1'b1);
    goto(1098 + LAT);
    check("c4_timeout", timeout, 0);

    // Case 5: wide ticks, then disable while timed out with a coincident edge.
    pulse_at(1192, 10, 1'b1);
    pulse_at(1288, 10, 1'b1);
    pulse_at(1384, 10, 1'b1);
    goto(1590);
    check("c5_timeout_set", timeout, 1);
    goto(1600);
    enable  = 1'b0;
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    check("c5_dis_timeout", timeout, 0);
    check("c5_dis_period", period, 96);
    check("c5_dis_valid", period_valid, 0);
    goto(1620);
    enable = 1'b1;
    pulse_at(1640, 1, 1'b0);
    pulse_at(1736, 1, 1'b1);

    // Case 6: asynchronous reset mid-measurement.
    goto(1760);
    check("c6_pre_ok", period_ok, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("c6_period", period, 0);
    check("c6_valid", period_valid, 0);
    check("c6_ok", period_ok, 0);
    check("c6_timeout", timeout, 0);
    goto(1765);
    reset_n = 1'b1;
    pulse_at(1780, 1, 1'b0);
    pulse_at(1876, 1, 1'b1);

    goto(1900);
    check("sb_empty", sb.size(), 0);
    check("end_timeout", timeout, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
